// File: rtl/rr_arbiter8.sv
// Eight-channel round-robin arbiter feeding a single registered output stage.
// Grant search starts at a rotating pointer; the output register stalls under backpressure.
module rr_arbiter8 #(
    parameter int unsigned N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_valid,
    input  logic [N-1:0] in_data0,
    input  logic [N-1:0] in_data1,
    input  logic [N-1:0] in_data2,
    input  logic [N-1:0] in_data3,
    input  logic [N-1:0] in_data4,
    input  logic [N-1:0] in_data5,
    input  logic [N-1:0] in_data6,
    input  logic [N-1:0] in_data7,
    output logic [7:0]   in_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic [2:0]   out_src,
    input  logic         out_ready
);

    localparam int unsigned CH = 8;
    localparam int unsigned SW = 3;

    logic [SW-1:0] ptr;
    logic          load;
    logic          grant_valid;
    logic [SW-1:0] grant_idx;
    logic [SW-1:0] cand;
    logic [N-1:0]  data_arr [CH];

    assign data_arr[0] = in_data0;
    assign data_arr[1] = in_data1;
    assign data_arr[2] = in_data2;
    assign data_arr[3] = in_data3;
    assign data_arr[4] = in_data4;
    assign data_arr[5] = in_data5;
    assign data_arr[6] = in_data6;
    assign data_arr[7] = in_data7;

    // Output register is empty or draining this cycle, so it can take a new word.
    assign load = !out_valid || out_ready;

    // Scan from the farthest offset down so the nearest valid channel to ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = int'(CH) - 1; i >= 0; i--) begin
            cand = ptr + SW'(i);
            if (in_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (!rst && load && grant_valid) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (load) begin
            if (grant_valid) begin
                out_valid <= 1'b1;
                out_data  <= data_arr[grant_idx];
                out_src   <= grant_idx;
                ptr       <= grant_idx + SW'(1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed and randomized checks of rr_arbiter8 against a round-robin reference model.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst;
    logic [7:0] in_valid;
    logic [7:0] dat [8];
    logic [7:0] in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] out_src;
    logic       out_ready;

    int checks   = 0;
    int failures = 0;

    // Reference state: pointer as a plain integer plus the expected output register.
    int         m_ptr   = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    int         m_src   = 0;

    rr_arbiter8 #(.N(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data0 (dat[0]),
        .in_data1 (dat[1]),
        .in_data2 (dat[2]),
        .in_data3 (dat[3]),
        .in_data4 (dat[4]),
        .in_data5 (dat[5]),
        .in_data6 (dat[6]),
        .in_data7 (dat[7]),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_src  (out_src),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First valid channel at or after the pointer, walking around modulo 8; -1 if none.
    function automatic int pick(input logic [7:0] v, input int p);
        for (int j = 0; j < 8; j++) begin
            if (v[(p + j) % 8]) return (p + j) % 8;
        end
        return -1;
    endfunction

    task automatic set_default_data();
        for (int k = 0; k < 8; k++) dat[k] = 8'(8'h10 + k);
    endtask

    // One clock: drive inputs, check in_ready before the edge, then outputs after it.
    task automatic step(input logic [7:0] v, input logic ordy, input logic r);
        int         g;
        logic       ld;
        logic [7:0] exp_rdy;
        in_valid  = v;
        out_ready = ordy;
        rst       = r;
        #1;
        ld      = !m_valid || ordy;
        g       = pick(v, m_ptr);
        exp_rdy = 8'h00;
        if (!r && ld && g >= 0) exp_rdy = 8'(1) << g;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (r) begin
            m_ptr = 0; m_valid = 1'b0; m_data = 8'h00; m_src = 0;
        end else if (ld) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = dat[g];
                m_src   = g;
                m_ptr   = (g + 1) % 8;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid || r) begin
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_src", 32'(out_src), 32'(m_src));
        end
    endtask

    initial begin
        logic [7:0] v;
        logic       ordy;
        logic       r;
        set_default_data();
        in_valid  = 8'h00;
        out_ready = 1'b1;
        rst       = 1'b1;

        // Reset with all channels requesting.
        step(8'hFF, 1'b1, 1'b1);
        step(8'hFF, 1'b1, 1'b1);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h00);
        chk("rst_src", 32'(out_src), 32'h0);

        // Full rotation.
        for (int i = 0; i < 9; i++) begin
            step(8'hFF, 1'b1, 1'b0);
            chk("rot_src", 32'(out_src), 32'(i % 8));
            chk("rot_data", 32'(out_data), 32'(8'h10 + (i % 8)));
            chk("rot_valid", 32'(out_valid), 32'h1);
        end

        // Sparse requesters 2 and 5 alternate.
        for (int i = 0; i < 4; i++) begin
            in_valid = 8'b0010_0100;
            #1;
            chk("sparse_rdy", 32'(in_ready), (i % 2 == 0) ? 32'h04 : 32'h20);
            step(8'b0010_0100, 1'b1, 1'b0);
            chk("sparse_src", 32'(out_src), (i % 2 == 0) ? 32'd2 : 32'd5);
        end

        // Backpressure: capture ch3 then stall three cycles.
        step(8'b0000_1000, 1'b1, 1'b0);
        chk("bp_cap", 32'(out_src), 32'd3);
        for (int i = 0; i < 3; i++) begin
            step(8'hFF, 1'b0, 1'b0);
            chk("bp_hold_data", 32'(out_data), 32'h13);
            chk("bp_hold_src", 32'(out_src), 32'd3);
            chk("bp_hold_valid", 32'(out_valid), 32'h1);
            chk("bp_hold_rdy", 32'(in_ready), 32'h00);
        end
        step(8'hFF, 1'b1, 1'b0);
        chk("bp_release", 32'(out_src), 32'd4);

        // Wrap from ch6 through 7 to 0, pointer back at 1.
        step(8'b0100_0000, 1'b1, 1'b0);
        chk("wrap_6", 32'(out_src), 32'd6);
        step(8'b1000_0001, 1'b1, 1'b0);
        chk("wrap_7", 32'(out_src), 32'd7);
        step(8'b1000_0001, 1'b1, 1'b0);
        chk("wrap_0", 32'(out_src), 32'd0);
        step(8'hFF, 1'b1, 1'b0);
        chk("wrap_ptr1", 32'(out_src), 32'd1);

        // Idle load drops out_valid but holds data and source.
        step(8'h00, 1'b1, 1'b0);
        chk("idle_valid", 32'(out_valid), 32'h0);
        chk("idle_src", 32'(out_src), 32'd1);

        // Reset in the middle of a stall.
        step(8'hFF, 1'b1, 1'b0);
        step(8'hFF, 1'b0, 1'b0);
        step(8'hFF, 1'b0, 1'b1);
        chk("rst_stall_valid", 32'(out_valid), 32'h0);
        step(8'hFF, 1'b1, 1'b0);
        chk("rst_stall_src", 32'(out_src), 32'd0);

        // Randomized traffic with random data, backpressure and occasional reset.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 8; k++) dat[k] = 8'($urandom);
            v    = 8'($urandom) & 8'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            r    = ($urandom_range(0, 50) == 0);
            step(v, ordy, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
